// File: rtl/rng_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) between rng_ctrl (master) and the memory side (slave).
interface rng_ctrl_if;
  logic [15:0]  awid_m;
  logic [63:0]  awaddr_m;
  logic [7:0]   awlen_m;
  logic [2:0]   awsize_m;
  logic         awvalid_m;
  logic         awready_m;
  logic [511:0] wdata_m;
  logic [63:0]  wstrb_m;
  logic         wlast_m;
  logic         wvalid_m;
  logic         wready_m;
  logic [15:0]  bid_m;
  logic [1:0]   bresp_m;
  logic         bvalid_m;
  logic         bready_m;

  modport master (
    output awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
    output wdata_m, wstrb_m, wlast_m, wvalid_m,
    output bready_m,
    input  awready_m, wready_m, bid_m, bresp_m, bvalid_m
  );

  modport slave (
    input  awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
    input  wdata_m, wstrb_m, wlast_m, wvalid_m,
    input  bready_m,
    output awready_m, wready_m, bid_m, bresp_m, bvalid_m
  );
endinterface

// File: rtl/rng_ctrl.sv
// rng_ctrl: streams random 64-byte beats from the generator core into memory with AXI write bursts.
// Configured through soft registers (base, length, seed, start, status, perf counter).
// Optional feature macro: RNG_CTRL_PERF_EN enables the busy-cycle counter read at 0x20.
module rng_ctrl #(
  parameter int unsigned BURST_BEATS     = 64,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              softreg_req_valid,
  input  logic              softreg_req_isWrite,
  input  logic [31:0]       softreg_req_addr,
  input  logic [63:0]       softreg_req_data,
  output logic              softreg_resp_valid,
  output logic [63:0]       softreg_resp_data,
  rng_ctrl_if.master        axi,
  input  logic [511:0]      rng_data,
  input  logic              rng_valid,
  output logic              rng_ready,
  output logic [63:0]       rng_seed,
  output logic              rng_seed_load
);

  localparam int unsigned BW = $clog2(BURST_BEATS + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [63:0] BURST_STRIDE = 64'(BURST_BEATS) << 6;
  localparam logic [31:0] REG_BASE   = 32'h00;
  localparam logic [31:0] REG_LEN    = 32'h08;
  localparam logic [31:0] REG_SEED   = 32'h10;
  localparam logic [31:0] REG_START  = 32'h18;
  localparam logic [31:0] REG_PERF   = 32'h20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     base_q, len_q, seed_q, rem_q, aw_addr_q;
  logic [7:0]      aw_len_q;
  logic            aw_valid_q, aw_valid_d;
  logic [BW-1:0]   beat_cnt_q;
  logic [OW-1:0]   out_q, out_d;
  logic            err_q, seed_load_q;
  logic            resp_valid_q;
  logic [63:0]     resp_data_q;
  logic [63:0]     perf_c;

  logic            busy_c, done_c, wr_c, rd_c, start_c, cfg_ok_c;
  logic            aw_hs_c, w_hs_c, b_hs_c, out_dec_c;
  logic [BW-1:0]   cur_burst_c;
  logic            unused_bid;

  // Beats in the next burst: the smaller of what remains and the burst cap.
  function automatic logic [BW-1:0] burst_of(input logic [63:0] n);
    return (n > 64'(BURST_BEATS)) ? BW'(BURST_BEATS) : BW'(n);
  endfunction

  // Handshakes, register-access decode and outstanding-count arithmetic.
  always_comb begin
    busy_c      = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_DRAIN);
    done_c      = (state_q == S_DONE);
    wr_c        = softreg_req_valid && softreg_req_isWrite;
    rd_c        = softreg_req_valid && !softreg_req_isWrite;
    start_c     = wr_c && (softreg_req_addr == REG_START) && !busy_c;
    cfg_ok_c    = wr_c && !busy_c;
    aw_hs_c     = aw_valid_q && axi.awready_m;
    w_hs_c      = (state_q == S_DATA) && rng_valid && axi.wready_m;
    b_hs_c      = axi.bvalid_m;
    out_dec_c   = b_hs_c && (out_q != '0);
    out_d       = out_q + OW'(aw_hs_c) - OW'(out_dec_c);
    cur_burst_c = burst_of(rem_q);
  end

  // Next-state logic and the registered AW-valid decision.
  always_comb begin
    state_d    = state_q;
    aw_valid_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_c) state_d = (len_q == '0) ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        if (aw_hs_c) state_d = S_DATA;
      end
      S_DATA: begin
        if (w_hs_c && (beat_cnt_q == BW'(1))) state_d = (rem_q == '0) ? S_DRAIN : S_ADDR;
      end
      S_DRAIN: begin
        if (out_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Only offer an address when the outstanding window has room after this cycle.
    aw_valid_d = (state_d == S_ADDR) && (out_d < OW'(MAX_OUTSTANDING));
  end

  // FSM state, AW valid and outstanding-response counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      aw_valid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      out_q      <= out_d;
    end
  end

  // Config registers, burst bookkeeping and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      seed_load_q <= 1'b0;
      rem_q       <= '0;
      aw_addr_q   <= '0;
      aw_len_q    <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      seed_load_q <= 1'b0;
      if (cfg_ok_c) begin
        case (softreg_req_addr)
          REG_BASE: base_q <= softreg_req_data;
          REG_LEN:  len_q  <= softreg_req_data;
          REG_SEED: begin
            seed_q      <= softreg_req_data;
            seed_load_q <= 1'b1;
          end
          default: ;
        endcase
      end
      if (b_hs_c && (axi.bresp_m != 2'b00)) err_q <= 1'b1;
      if (start_c) begin
        rem_q     <= len_q;
        aw_addr_q <= {base_q[63:6], 6'b0};
        aw_len_q  <= 8'(burst_of(len_q) - BW'(1));
        err_q     <= 1'b0;
      end else if (aw_hs_c) begin
        rem_q      <= rem_q - 64'(cur_burst_c);
        aw_addr_q  <= aw_addr_q + BURST_STRIDE;
        aw_len_q   <= 8'(burst_of(rem_q - 64'(cur_burst_c)) - BW'(1));
        beat_cnt_q <= cur_burst_c;
      end
      if (w_hs_c) beat_cnt_q <= beat_cnt_q - BW'(1);
    end
  end

  // Soft register read port: one-cycle registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= rd_c;
      case (softreg_req_addr)
        REG_BASE:  resp_data_q <= base_q;
        REG_LEN:   resp_data_q <= len_q;
        REG_SEED:  resp_data_q <= seed_q;
        REG_START: resp_data_q <= {61'b0, err_q, busy_c, done_c};
        REG_PERF:  resp_data_q <= perf_c;
        default:   resp_data_q <= '0;
      endcase
    end
  end

`ifdef RNG_CTRL_PERF_EN
  logic [63:0] perf_q;

  // Saturating count of busy cycles for the most recent run.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (start_c) begin
      perf_q <= '0;
    end else if (busy_c && (perf_q != '1)) begin
      perf_q <= perf_q + 64'(1);
    end
  end

  assign perf_c = perf_q;
`else
  assign perf_c = '0;
`endif

  // AXI drive: AW from registers, W is a gated pass-through of the generator stream.
  assign axi.awid_m    = '0;
  assign axi.awaddr_m  = aw_addr_q;
  assign axi.awlen_m   = aw_len_q;
  assign axi.awsize_m  = 3'd6;
  assign axi.awvalid_m = aw_valid_q;
  assign axi.wdata_m   = rng_data;
  assign axi.wstrb_m   = '1;
  assign axi.wlast_m   = (state_q == S_DATA) && (beat_cnt_q == BW'(1));
  assign axi.wvalid_m  = (state_q == S_DATA) && rng_valid;
  assign axi.bready_m  = 1'b1;
  assign rng_ready     = (state_q == S_DATA) && axi.wready_m;

  assign rng_seed           = seed_q;
  assign rng_seed_load      = seed_load_q;
  assign softreg_resp_valid = resp_valid_q;
  assign softreg_resp_data  = resp_data_q;

  // Single-ID design: response IDs carry no information here.
  assign unused_bid = ^axi.bid_m;

endmodule
